alpha_fade_sequencer: RTL
=========================

ALPHA_FADE_SEQUENCER -- requirements
Module: alpha_fade_sequencer

Interface
REQ-001 ALPHA_STEP, 8, alpha increment/decrement applied per step (1..256).
REQ-002 FRAMES_PER_STEP, 1, frame_start pulses per ramp step (1..255).
REQ-003 HOLD_FRAMES, 60, frame_start pulses spent at an endpoint in auto mode (1..1023).
REQ-004 clk  input  1  system clock; the block SHALL use this one clock only.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_flag  input  1  one-cycle pulse, key event valid (from key scanner).
REQ-007 key_value  input  2  key code qualified by key_flag: 01 ramp up, 10 ramp down, 11 abort.
REQ-008 auto_mode  input  1  level; 1 enables continuous ping-pong fading.
REQ-009 frame_start  input  1  one-cycle pulse at VGA frame boundary.
REQ-010 alpha_data  output  9  blend coefficient to blender, range 0..256.
REQ-011 busy  output  1  high in any state except IDLE.
REQ-012 ramp_done  output  1  one-cycle pulse when a ramp reaches its endpoint.

Function
REQ-013 States SHALL be IDLE, RAMP_UP, RAMP_DOWN, HOLD; busy = (state != IDLE).
REQ-014 alpha_data SHALL change only in the cycle after a frame_start pulse (registered; latency 1 clk), never mid-frame.
REQ-015 In RAMP_UP/RAMP_DOWN a step counter SHALL count frame_start pulses; on the FRAMES_PER_STEP-th pulse alpha_data SHALL move by ALPHA_STEP and the counter SHALL clear.
REQ-016 Arithmetic SHALL be 10-bit internal; results above 256 SHALL clamp to 256, below 0 SHALL clamp to 0.
REQ-017 When alpha_data reaches 256 (RAMP_UP) or 0 (RAMP_DOWN), ramp_done SHALL pulse in that same update cycle; next state SHALL be HOLD if auto_mode=1, else IDLE.
REQ-018 IDLE: key 01 -> RAMP_UP, key 10 -> RAMP_DOWN, step counter cleared; key 01 at alpha 256 or 10 at alpha 0 SHALL pulse ramp_done and stay IDLE.
REQ-019 IDLE with auto_mode=1: on frame_start go RAMP_UP if alpha_data<256, else RAMP_DOWN; no alpha change on that pulse.
REQ-020 During a ramp, the opposite direction key SHALL reverse direction next cycle, clearing the step counter; the same-direction key SHALL be ignored.
REQ-021 Key 11 in any state SHALL go to IDLE next cycle, alpha_data held.
REQ-022 HOLD SHALL count HOLD_FRAMES frame_start pulses, then enter the ramp opposite to the endpoint reached (256 -> RAMP_DOWN, 0 -> RAMP_UP).
REQ-023 auto_mode falling during HOLD SHALL go to IDLE next cycle; falling during a ramp SHALL let the ramp finish to IDLE.
REQ-024 key_flag and frame_start in the same cycle: key transition SHALL take priority and no alpha step SHALL occur on that frame_start.
REQ-025 key_flag with key_value 00 SHALL be ignored.

Reset
REQ-026 On rst_n low: state IDLE, alpha_data 127, busy 0, ramp_done 0, step and hold counters 0, all immediately (asynchronous).
REQ-027 Reset asserted mid-ramp SHALL abandon the ramp; after release, no alpha change until a new key or auto start.

Structure
REQ-028 A shared package SHALL hold the state encoding, ALPHA_MAX=256, ALPHA_MIN=0, ALPHA_RESET=127 and the key code constants 01/10/11.
REQ-029 Frame-step counting SHALL be one sub-module, frame_step_divider (frame_start in, clear in, step pulse out, parameter FRAMES_PER_STEP).

Verification
REQ-030 Reset, key 01, ALPHA_STEP=8, FRAMES_PER_STEP=1, 17 frame_starts -> alpha 135,143,...,255,256; ramp_done on the 256 update; IDLE after.
REQ-031 alpha 127, FRAMES_PER_STEP=4, key 10 -> alpha changes only every 4th frame_start, 127->119 after 4 pulses, 1 clk after pulse.
REQ-032 RAMP_UP at alpha 200, key 10 -> RAMP_DOWN; next step gives 192; key 11 -> IDLE, alpha 192 frozen across 10 frames.
REQ-033 auto_mode=1, HOLD_FRAMES=3, alpha 248 -> 256, ramp_done, 3 frames HOLD, then 248, 240...; drop auto_mode in HOLD -> IDLE.
REQ-034 key_flag and frame_start in the same cycle from IDLE with key 01 -> RAMP_UP, alpha unchanged that frame, first step on the next frame.
REQ-035 rst_n pulsed low mid-ramp at alpha 180 -> alpha 127, busy 0 immediately, no change over following frames.

Source files
------------

// File: rtl/alpha_fade_sequencer_pkg.sv
// Shared constants for the alpha fade sequencer: state encoding, alpha limits,
// key codes and the clamped step arithmetic used by the ramp states.
package alpha_fade_sequencer_pkg;

    localparam int unsigned ALPHA_W = 9;
    localparam int unsigned CALC_W  = 10;
    localparam int unsigned HOLD_W  = 10;
    localparam int unsigned KEY_W   = 2;
    localparam int unsigned STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ALPHA_W-1:0] alpha_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RAMP_UP   = 2'd1;
    localparam state_t ST_RAMP_DOWN = 2'd2;
    localparam state_t ST_HOLD      = 2'd3;

    localparam alpha_t ALPHA_MAX   = 9'd256;
    localparam alpha_t ALPHA_MIN   = 9'd0;
    localparam alpha_t ALPHA_RESET = 9'd127;

    localparam logic [KEY_W-1:0] KEY_UP    = 2'b01;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 2'b10;
    localparam logic [KEY_W-1:0] KEY_ABORT = 2'b11;

    // Widened add so a step past the top saturates instead of wrapping.
    function automatic alpha_t alpha_step_up(input alpha_t a, input logic [CALC_W-1:0] step);
        logic [CALC_W-1:0] sum;
        sum = CALC_W'(a) + step;
        return (sum > CALC_W'(ALPHA_MAX)) ? ALPHA_MAX : ALPHA_W'(sum);
    endfunction

    function automatic alpha_t alpha_step_down(input alpha_t a, input logic [CALC_W-1:0] step);
        logic [CALC_W-1:0] diff;
        diff = CALC_W'(a) - step;
        return (CALC_W'(a) < step) ? ALPHA_MIN : ALPHA_W'(diff);
    endfunction

endpackage

// File: rtl/alpha_fade_sequencer_if.sv
// Key, frame and blend-coefficient signals between the controller side and
// the fade sequencer.
interface alpha_fade_sequencer_if;
    import alpha_fade_sequencer_pkg::*;

    logic               key_flag;
    logic [KEY_W-1:0]   key_value;
    logic               auto_mode;
    logic               frame_start;
    logic [ALPHA_W-1:0] alpha_data;
    logic               busy;
    logic               ramp_done;

    modport master (
        output key_flag,
        output key_value,
        output auto_mode,
        output frame_start,
        input  alpha_data,
        input  busy,
        input  ramp_done
    );

    modport slave (
        input  key_flag,
        input  key_value,
        input  auto_mode,
        input  frame_start,
        output alpha_data,
        output busy,
        output ramp_done
    );

endinterface

// File: rtl/alpha_fade_sequencer_frame_step_divider.sv
// Counts frame pulses and emits a same-cycle step pulse on every
// FRAMES_PER_STEP-th one; clear wins over counting.
module frame_step_divider #(
    parameter int unsigned FRAMES_PER_STEP = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic clear,
    output logic step_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_terminal_c;

    assign at_terminal_c = (cnt_q == CNT_W'(FRAMES_PER_STEP - 1));
    assign step_c        = frame_start && at_terminal_c;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (frame_start) begin
            cnt_d = at_terminal_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alpha_fade_sequencer.sv
// Frame-synchronous alpha fade controller: key-driven or auto ping-pong ramps
// between 0 and 256, alpha only ever updated right after a frame boundary.
module alpha_fade_sequencer
    import alpha_fade_sequencer_pkg::*;
#(
    parameter int unsigned ALPHA_STEP      = 8,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned HOLD_FRAMES     = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alpha_fade_sequencer_if.slave bus
);

    state_t             state_q, state_d;
    alpha_t             alpha_q, alpha_d;
    logic               ramp_done_q, ramp_done_d;
    logic               busy_q, busy_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic   in_ramp_c;
    logic   key_up_c, key_down_c, key_abort_c;
    logic   key_eff_c;
    logic   div_frame_c, div_clear_c, step_c;
    alpha_t step_up_c, step_dn_c;

    // Key decode; key_eff_c marks keys that actually redirect an active ramp.
    always_comb begin
        in_ramp_c   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
        key_up_c    = bus.key_flag && (bus.key_value == KEY_UP);
        key_down_c  = bus.key_flag && (bus.key_value == KEY_DOWN);
        key_abort_c = bus.key_flag && (bus.key_value == KEY_ABORT);
        key_eff_c   = key_abort_c
                    || ((state_q == ST_RAMP_UP)   && key_down_c)
                    || ((state_q == ST_RAMP_DOWN) && key_up_c);
        div_frame_c = bus.frame_start && in_ramp_c && !key_eff_c;
        div_clear_c = !in_ramp_c || key_eff_c;
        step_up_c   = alpha_step_up(alpha_q, CALC_W'(ALPHA_STEP));
        step_dn_c   = alpha_step_down(alpha_q, CALC_W'(ALPHA_STEP));
    end

    frame_step_divider #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_divider (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (div_frame_c),
        .clear       (div_clear_c),
        .step_c      (step_c)
    );

    always_comb begin
        state_d     = state_q;
        alpha_d     = alpha_q;
        ramp_done_d = 1'b0;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (key_up_c) begin
                    if (alpha_q == ALPHA_MAX) ramp_done_d = 1'b1;
                    else                      state_d     = ST_RAMP_UP;
                end else if (key_down_c) begin
                    if (alpha_q == ALPHA_MIN) ramp_done_d = 1'b1;
                    else                      state_d     = ST_RAMP_DOWN;
                end else if (bus.auto_mode && bus.frame_start && !key_abort_c) begin
                    state_d = (alpha_q < ALPHA_MAX) ? ST_RAMP_UP : ST_RAMP_DOWN;
                end
            end

            ST_RAMP_UP: begin
                hold_cnt_d = '0;
                if (key_abort_c) begin
                    state_d = ST_IDLE;
                end else if (key_down_c) begin
                    state_d = ST_RAMP_DOWN;
                end else if (step_c) begin
                    alpha_d = step_up_c;
                    if (step_up_c == ALPHA_MAX) begin
                        ramp_done_d = 1'b1;
                        state_d     = bus.auto_mode ? ST_HOLD : ST_IDLE;
                    end
                end
            end

            ST_RAMP_DOWN: begin
                hold_cnt_d = '0;
                if (key_abort_c) begin
                    state_d = ST_IDLE;
                end else if (key_up_c) begin
                    state_d = ST_RAMP_UP;
                end else if (step_c) begin
                    alpha_d = step_dn_c;
                    if (step_dn_c == ALPHA_MIN) begin
                        ramp_done_d = 1'b1;
                        state_d     = bus.auto_mode ? ST_HOLD : ST_IDLE;
                    end
                end
            end

            ST_HOLD: begin
                if (key_abort_c || !bus.auto_mode) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end else if (bus.frame_start) begin
                    if (hold_cnt_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_cnt_d = '0;
                        state_d    = (alpha_q == ALPHA_MAX) ? ST_RAMP_DOWN : ST_RAMP_UP;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alpha_q     <= ALPHA_RESET;
            ramp_done_q <= 1'b0;
            busy_q      <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            alpha_q     <= alpha_d;
            ramp_done_q <= ramp_done_d;
            busy_q      <= busy_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.alpha_data = alpha_q;
    assign bus.busy       = busy_q;
    assign bus.ramp_done  = ramp_done_q;

endmodule
